// File: rtl/crc_chk_param.sv
// crc_chk_param: streaming CRC checker that absorbs DATA_W bits per beat and reports the residue per frame.
// Optional saturating error counter (ports err_cnt_clr / err_cnt) enabled by defining CRC_CHK_ERR_CNT_EN.
module crc_chk_param #(
    parameter int unsigned      CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(16'h8005),
    parameter logic [CRC_W-1:0] INIT   = {CRC_W{1'b1}},
    parameter int unsigned      DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_abort,
`ifdef CRC_CHK_ERR_CNT_EN
    input  logic              err_cnt_clr,
    output logic [7:0]        err_cnt,
`endif
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              crc_ok
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_ACCUM = 2'd1;
    localparam logic [1:0]  S_CHECK = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_crc_nxt;
    logic [CRC_W-1:0] w_seed;
    logic [CRC_W-1:0] w_absorbed;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_crc_ok;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_error_nxt;
    logic             w_crc_ok_nxt;

    // Unrolled serial LFSR: in_data MSB is absorbed first, all DATA_W steps in one cycle.
    function automatic logic [CRC_W-1:0] f_absorb(input logic [CRC_W-1:0] crc,
                                                   input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb = c[CRC_W-1] ^ data[DATA_W-1-i];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        return c;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, CRC register update and registered status
    always_comb begin
        w_state_nxt  = r_state;
        w_crc_nxt    = r_crc;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_error_nxt  = r_error;
        w_crc_ok_nxt = r_crc_ok;
        // Only a frame already in progress continues from the register; any other beat starts fresh.
        w_seed       = (r_state == S_ACCUM) ? r_crc : INIT;
        w_absorbed   = f_absorb(w_seed, in_data);

        if (in_abort) begin
            w_state_nxt  = S_IDLE;
            w_crc_nxt    = INIT;
            w_error_nxt  = 1'b0;
            w_crc_ok_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_CHECK: begin
                    if (in_valid) begin
                        w_crc_nxt   = w_absorbed;
                        w_state_nxt = in_last ? S_CHECK : S_ACCUM;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        w_crc_nxt   = w_absorbed;
                        w_state_nxt = in_last ? S_CHECK : S_ACCUM;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_crc_nxt   = INIT;
                end
            endcase

            if (w_state_nxt == S_CHECK) begin
                w_done_nxt   = 1'b1;
                w_error_nxt  = (w_absorbed != '0);
                w_crc_ok_nxt = (w_absorbed == '0);
            end
        end

        w_busy_nxt = (w_state_nxt == S_ACCUM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_crc    <= INIT;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_crc_ok <= 1'b0;
        end else begin
            r_crc    <= w_crc_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_error  <= w_error_nxt;
            r_crc_ok <= w_crc_ok_nxt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;
    assign crc_ok = r_crc_ok;

`ifdef CRC_CHK_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_err_cnt;

    // Counts errored done pulses; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_cnt <= '0;
        end else if (err_cnt_clr) begin
            r_err_cnt <= '0;
        end else if (r_done && r_error && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_crc_chk_param.sv
// Self-checking bench for crc_chk_param: DATA_W=1 and DATA_W=8 instances against a polynomial-division model.
// Counter checks are compiled in when CRC_CHK_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module tb_crc_chk_param;

    localparam logic [16:0] GEN  = 17'h18005;
    localparam logic [15:0] SEED = 16'hFFFF;

    logic       clk = 1'b0;
    logic       reset;
    logic       v1, l1, a1;
    logic [0:0] d1;
    logic       b1, dn1, e1, ok1;
    logic       v8, l8, a8;
    logic [7:0] d8;
    logic       b8, dn8, e8, ok8;
`ifdef CRC_CHK_ERR_CNT_EN
    logic       clr1, clr8;
    logic [7:0] cnt1, cnt8;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic q_bits[$];

    crc_chk_param #(.DATA_W(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_data(d1), .in_last(l1), .in_abort(a1),
`ifdef CRC_CHK_ERR_CNT_EN
        .err_cnt_clr(clr1), .err_cnt(cnt1),
`endif
        .busy(b1), .done(dn1), .error(e1), .crc_ok(ok1)
    );

    crc_chk_param #(.DATA_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_data(d8), .in_last(l8), .in_abort(a8),
`ifdef CRC_CHK_ERR_CNT_EN
        .err_cnt_clr(clr8), .err_cnt(cnt8),
`endif
        .busy(b8), .done(dn8), .error(e8), .crc_ok(ok8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        v1 = 1'b0; l1 = 1'b0; a1 = 1'b0; d1 = 1'b0;
        v8 = 1'b0; l8 = 1'b0; a8 = 1'b0; d8 = 8'h00;
`ifdef CRC_CHK_ERR_CNT_EN
        clr1 = 1'b0; clr8 = 1'b0;
`endif
    endtask

    // Register after n bits = (SEED*x^n + M(x)*x^16) mod G, by long division over a bit list.
    function automatic logic [15:0] model_rem(input int n);
        logic        b[$];
        logic [15:0] s;
        logic [16:0] g;
        logic [15:0] r;
        s = SEED;
        g = GEN;
        b = {};
        for (int i = 0; i < n; i++) b.push_back(q_bits[i]);
        for (int i = 0; i < 16; i++) b.push_back(1'b0);
        for (int i = 0; i < 16; i++) b[i] = b[i] ^ s[15-i];
        for (int i = 0; i < n; i++)
            if (b[i])
                for (int j = 0; j < 17; j++) b[i+j] = b[i+j] ^ g[16-j];
        for (int i = 0; i < 16; i++) r[15-i] = b[n+i];
        return r;
    endfunction

    task automatic append_crc();
        logic [15:0] c;
        c = model_rem(q_bits.size());
        for (int i = 0; i < 16; i++) q_bits.push_back(c[15-i]);
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) q_bits.push_back(v[i]);
    endtask

    // Drives q_bits into the DATA_W=1 instance and checks every cycle plus the check result.
    task automatic send1(input string tag, input bit gaps);
        int   n;
        int   ng;
        logic exp_err;
        n = q_bits.size();
        exp_err = (model_rem(n) != 16'h0000);
        for (int i = 0; i < n; i++) begin
            ng = gaps ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < ng; g++) begin
                v1 = 1'b0; l1 = 1'($urandom_range(0, 1)); d1 = 1'($urandom_range(0, 1));
                tick();
                checks++;
                if ({dn1, b1} !== {1'b0, (i > 0)}) begin
                    errors++;
                    $display("FAIL %s gap: done,busy=%b required %b", tag, {dn1, b1}, {1'b0, (i > 0)});
                end
            end
            v1 = 1'b1; d1 = q_bits[i]; l1 = (i == n - 1);
            tick();
            if (i < n - 1) begin
                checks++;
                if ({dn1, b1} !== 2'b01) begin
                    errors++;
                    $display("FAIL %s beat %0d: done,busy=%b required 01", tag, i, {dn1, b1});
                end
            end
        end
        v1 = 1'b0; l1 = 1'b0;
        checks++;
        if ({dn1, b1, e1, ok1} !== {2'b10, exp_err, ~exp_err}) begin
            errors++;
            $display("FAIL %s check: done,busy,error,crc_ok=%b required %b",
                     tag, {dn1, b1, e1, ok1}, {2'b10, exp_err, ~exp_err});
        end
        tick();
        checks++;
        if ({dn1, b1, e1, ok1} !== {2'b00, exp_err, ~exp_err}) begin
            errors++;
            $display("FAIL %s after: done,busy,error,crc_ok=%b required %b",
                     tag, {dn1, b1, e1, ok1}, {2'b00, exp_err, ~exp_err});
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({b1, dn1, e1, ok1, b8, dn8, e8, ok8} !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: outputs=%b required 00000000", {b1, dn1, e1, ok1, b8, dn8, e8, ok8});
        end
        tick();
        tick();
        checks++;
        if ({b1, dn1, e1, ok1, b8, dn8, e8, ok8} !== 8'h00) begin
            errors++;
            $display("FAIL reset_held: outputs=%b required 00000000", {b1, dn1, e1, ok1, b8, dn8, e8, ok8});
        end
`ifdef CRC_CHK_ERR_CNT_EN
        checks++;
        if ({cnt1, cnt8} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cnt: err_cnt=%h/%h required 00/00", cnt1, cnt8);
        end
`endif
        reset = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        q_bits = {};
        push_byte(8'hA5);
        append_crc();
        send1("good_a5", 1'b0);
        checks++;
        if (ok1 !== 1'b1) begin
            errors++;
            $display("FAIL good_a5 crc_ok: got %b required 1", ok1);
        end
    endtask

    task automatic test_bad_frame();
        q_bits = {};
        push_byte(8'hA5);
        append_crc();
        q_bits[q_bits.size() - 1 - 3] = ~q_bits[q_bits.size() - 1 - 3];
        send1("bad_a5", 1'b0);
        checks++;
        if ({e1, ok1} !== 2'b10) begin
            errors++;
            $display("FAIL bad_a5 flags: error,crc_ok=%b required 10", {e1, ok1});
        end
`ifdef CRC_CHK_ERR_CNT_EN
        checks++;
        if (cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL bad_a5 err_cnt: got %0d required 1", cnt1);
        end
`endif
    endtask

    task automatic test_last_without_valid();
        for (int i = 0; i < 3; i++) begin
            v1 = 1'b0; l1 = 1'b1; d1 = 1'b1;
            tick();
            checks++;
            if ({dn1, b1} !== 2'b00) begin
                errors++;
                $display("FAIL last_no_valid %0d: done,busy=%b required 00", i, {dn1, b1});
            end
        end
        l1 = 1'b0;
    endtask

    task automatic test_random();
        int n;
        int p;
        for (int f = 0; f < 8; f++) begin
            n = int'($urandom_range(1, 20));
            q_bits = {};
            for (int i = 0; i < n; i++) q_bits.push_back(1'($urandom_range(0, 1)));
            append_crc();
            if ($urandom_range(0, 1) == 1) begin
                p = int'($urandom_range(0, q_bits.size() - 1));
                q_bits[p] = ~q_bits[p];
            end
            send1("rand1", 1'b1);
        end
    endtask

    // Random frames of 1..3 payload bytes on the byte-wide instance, driven with no gaps.
    task automatic test_back_to_back();
        logic [7:0] beats[$];
        logic       lasts[$];
        logic       errs[$];
        int         done_cyc[$];
        logic [7:0] by;
        int         nb;
        int         fi;
        int         p;
        for (int f = 0; f < 6; f++) begin
            q_bits = {};
            nb = (f < 2) ? 1 : int'($urandom_range(1, 3));
            for (int k = 0; k < nb; k++) push_byte(8'($urandom));
            append_crc();
            if (f >= 2 && $urandom_range(0, 1) == 1) begin
                p = int'($urandom_range(0, q_bits.size() - 1));
                q_bits[p] = ~q_bits[p];
            end
            errs.push_back(model_rem(q_bits.size()) != 16'h0000);
            for (int k = 0; k < q_bits.size() / 8; k++) begin
                for (int j = 0; j < 8; j++) by[7-j] = q_bits[8*k + j];
                beats.push_back(by);
                lasts.push_back(k == q_bits.size() / 8 - 1);
            end
        end
        fi = 0;
        for (int i = 0; i < beats.size(); i++) begin
            v8 = 1'b1; d8 = beats[i]; l8 = lasts[i];
            tick();
            checks++;
            if ({dn8, b8} !== {lasts[i], ~lasts[i]}) begin
                errors++;
                $display("FAIL b2b beat %0d: done,busy=%b required %b", i, {dn8, b8}, {lasts[i], ~lasts[i]});
            end
            if (lasts[i]) begin
                checks++;
                if ({e8, ok8} !== {errs[fi], ~errs[fi]}) begin
                    errors++;
                    $display("FAIL b2b frame %0d: error,crc_ok=%b required %b", fi, {e8, ok8}, {errs[fi], ~errs[fi]});
                end
                if (dn8 === 1'b1) done_cyc.push_back(cyc);
                fi++;
            end
        end
        v8 = 1'b0; l8 = 1'b0;
        tick();
        checks++;
        if (dn8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b tail: done=%b required 0", dn8);
        end
        checks++;
        if (done_cyc.size() < 2 || done_cyc[1] - done_cyc[0] != 3) begin
            errors++;
            $display("FAIL b2b spacing: first two done pulses %0d cycles apart required 3",
                     (done_cyc.size() < 2) ? -1 : done_cyc[1] - done_cyc[0]);
        end
    endtask

    task automatic test_abort();
        q_bits = {};
        push_byte(8'h3C);
        append_crc();
        q_bits[0] = ~q_bits[0];
        send1("pre_abort", 1'b0);
        v1 = 1'b1; d1 = 1'b1; l1 = 1'b0;
        tick();
        a1 = 1'b1; d1 = 1'b0;
        tick();
        a1 = 1'b0; v1 = 1'b0;
        checks++;
        if ({b1, dn1, e1, ok1} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_beat2: busy,done,error,crc_ok=%b required 0000", {b1, dn1, e1, ok1});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({b1, dn1} !== 2'b00) begin
                errors++;
                $display("FAIL abort_idle %0d: busy,done=%b required 00", i, {b1, dn1});
            end
        end
        v1 = 1'b1; d1 = 1'b0; l1 = 1'b0;
        tick();
        l1 = 1'b1; a1 = 1'b1;
        tick();
        v1 = 1'b0; l1 = 1'b0; a1 = 1'b0;
        checks++;
        if ({b1, dn1} !== 2'b00) begin
            errors++;
            $display("FAIL abort_last: busy,done=%b required 00", {b1, dn1});
        end
        q_bits = {};
        push_byte(8'h96);
        append_crc();
        send1("post_abort", 1'b0);
    endtask

    task automatic test_reset_mid();
        q_bits = {};
        push_byte(8'h5A);
        append_crc();
        send1("pre_reset", 1'b0);
        for (int i = 0; i < 5; i++) begin
            v1 = 1'b1; d1 = 1'($urandom_range(0, 1)); l1 = 1'b0;
            tick();
        end
        v1 = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({b1, dn1, e1, ok1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: busy,done,error,crc_ok=%b required 0000", {b1, dn1, e1, ok1});
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({b1, dn1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_release: busy,done=%b required 00", {b1, dn1});
        end
        q_bits = {};
        push_byte(8'hA5);
        append_crc();
        send1("post_reset", 1'b1);
    endtask

`ifdef CRC_CHK_ERR_CNT_EN
    // One-byte frames every cycle; the count reflects errored done pulses of earlier cycles.
    task automatic test_err_cnt();
        int         exp_cnt;
        logic       prev_err;
        logic       cur_err;
        logic [7:0] by;
        int         k;
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        exp_cnt = 0;
        prev_err = 1'b0;
        k = 0;
        while (k < 400 && !(exp_cnt == 255 && k > 270)) begin
            by = 8'($urandom);
            q_bits = {};
            push_byte(by);
            cur_err = (model_rem(8) != 16'h0000);
            v8 = 1'b1; l8 = 1'b1; d8 = by;
            tick();
            if (prev_err && exp_cnt < 255) exp_cnt++;
            checks++;
            if (cnt8 !== 8'(exp_cnt) || {dn8, e8} !== {1'b1, cur_err}) begin
                errors++;
                $display("FAIL err_cnt step %0d: err_cnt=%0d done,error=%b required %0d %b",
                         k, cnt8, {dn8, e8}, exp_cnt, {1'b1, cur_err});
            end
            prev_err = cur_err;
            k++;
        end
        v8 = 1'b0; l8 = 1'b0;
        tick();
        tick();
        checks++;
        if (cnt8 !== 8'd255) begin
            errors++;
            $display("FAIL err_cnt saturate: got %0d required 255", cnt8);
        end
        cur_err = 1'b0;
        for (int t = 0; t < 100 && !cur_err; t++) begin
            by = 8'($urandom);
            q_bits = {};
            push_byte(by);
            cur_err = (model_rem(8) != 16'h0000);
        end
        v8 = 1'b1; l8 = 1'b1; d8 = by;
        tick();
        v8 = 1'b0; l8 = 1'b0; clr8 = 1'b1;
        checks++;
        if ({dn8, e8} !== 2'b11) begin
            errors++;
            $display("FAIL err_cnt clr_setup: done,error=%b required 11", {dn8, e8});
        end
        tick();
        clr8 = 1'b0;
        checks++;
        if (cnt8 !== 8'd0) begin
            errors++;
            $display("FAIL err_cnt clr_priority: got %0d required 0", cnt8);
        end
        tick();
        checks++;
        if (cnt8 !== 8'd0) begin
            errors++;
            $display("FAIL err_cnt clr_hold: got %0d required 0", cnt8);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        idle_all();
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_last_without_valid();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef CRC_CHK_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        if (errors == 0)
            $display("PASS");
        else
            $display("FAIL");
        $finish;
    end

endmodule

// File: doc/crc_chk_param.md
CRC_CHK_PARAM -- requirements
Module: crc_chk_param

Interface
REQ-001 Parameter CRC_W, 16, CRC register width in bits; legal range 8..32.
REQ-002 Parameter POLY, 16'h8005, generator polynomial with implicit top term; default is x^16+x^15+x^2+1.
REQ-003 Parameter INIT, all-ones of CRC_W, register seed loaded at frame start.
REQ-004 Parameter DATA_W, 1, bits absorbed per accepted beat; legal range 1..16.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  beat qualifier.
REQ-008 in_data  input  DATA_W  beat payload; in_data[DATA_W-1] is absorbed first.
REQ-009 in_last  input  1  marks final beat of frame (received CRC field included); sampled only with in_valid.
REQ-010 in_abort  input  1  discards the frame in progress.
REQ-011 busy  output  1  high while state is ACCUM.
REQ-012 done  output  1  one-cycle pulse, frame check complete.
REQ-013 error  output  1  residue nonzero for the last checked frame.
REQ-014 crc_ok  output  1  residue zero for the last checked frame.

Function
REQ-015 The block SHALL implement states IDLE, ACCUM, CHECK.
REQ-016 IDLE: in_valid & !in_last -> ACCUM; in_valid & in_last -> CHECK; register seeded from INIT, then the beat absorbed in the same cycle.
REQ-017 ACCUM: each in_valid beat SHALL advance the register by DATA_W serial LFSR steps (feedback = reg[CRC_W-1] ^ bit; shift left; XOR POLY when feedback is 1), MSB-first.
REQ-018 ACCUM with in_valid low SHALL hold the register and the state; no timeout.
REQ-019 ACCUM: in_valid & in_last -> CHECK after absorbing that beat.
REQ-020 CHECK lasts exactly one cycle: done=1; error=(reg!=0); crc_ok=(reg==0); latency from the in_last beat to done is 1 cycle.
REQ-021 CHECK: in_valid starts a new frame from INIT (same rules as IDLE), so back-to-back frames need no idle cycle; otherwise -> IDLE.
REQ-022 error and crc_ok SHALL be updated only in CHECK and held until the next CHECK, reset, or abort; they are never both 1.
REQ-023 in_abort SHALL take priority over in_valid in every state: -> IDLE, register reloaded with INIT, no done, error and crc_ok cleared to 0.
REQ-024 in_abort in the same cycle as an in_last beat SHALL suppress that frame's done.
REQ-025 in_last without in_valid SHALL be ignored.
REQ-026 The register update SHALL be fully combinational within one cycle for any DATA_W; no multicycle paths.

Reset
REQ-027 On reset low: state IDLE, register = INIT, busy=0, done=0, error=0, crc_ok=0, err_cnt=0 (when present), regardless of the clock.
REQ-028 Reset asserted mid-frame SHALL discard the frame with no done pulse; the first beat after release starts a fresh frame.

Configuration
REQ-029 Macro CRC_CHK_ERR_CNT_EN defined: adds input err_cnt_clr (1 bit) and output err_cnt (8 bits); err_cnt increments on each done with error=1 and saturates at 255.
REQ-030 err_cnt_clr SHALL zero err_cnt synchronously and take priority over a same-cycle increment.
REQ-031 Macro undefined: err_cnt_clr and err_cnt SHALL be absent from the port list; all other behaviour is identical.

Verification
REQ-032 Defaults, DATA_W=1: 8 payload bits 0xA5 plus their correct 16 CRC bits (from the model), in_last on the 24th bit -> done=1 on the next cycle, crc_ok=1, error=0.
REQ-033 Same frame with CRC bit 3 flipped -> done=1, error=1, crc_ok=0; err_cnt 0->1 with macro defined.
REQ-034 DATA_W=8: two back-to-back 3-byte frames, no gap -> two done pulses exactly 3 cycles apart, both crc_ok=1.
REQ-035 in_abort asserted on beat 2 of a frame -> no done; busy=0 the next cycle; error=crc_ok=0.
REQ-036 Reset pulsed mid-frame, then a valid frame -> register restarts from 16'hFFFF, crc_ok=1.
REQ-037 Macro defined: 256 errored frames -> err_cnt=255 and held; err_cnt_clr together with an errored done -> err_cnt=0.
